// File: rtl/hub75_column_driver.sv
// hub75_column_driver: requests column pairs and drives them onto a HUB75 panel
// as three-plane binary-coded modulation.
module hub75_column_driver #(
  parameter int NUM_ROWS  = 64,
  parameter int SCAN_RATE = 32,
  parameter int RGB_RES   = 9,
  parameter int BASE_ON   = 4
) (
  input  logic                                      clk_in,
  input  logic                                      rst_n_in,
  input  logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0]     columns,
  input  logic [$clog2(SCAN_RATE)-1:0]              col_num1,
  input  logic [$clog2(SCAN_RATE):0]                col_num2,
  input  logic                                      data_valid,
  output logic                                      hub75_ready,
  output logic [2:0]                                rgb1,
  output logic [2:0]                                rgb2,
  output logic [$clog2(SCAN_RATE)-1:0]              addr,
  output logic                                      hub75_clk,
  output logic                                      hub75_lat,
  output logic                                      hub75_oe_n
);
  localparam int AW = $clog2(SCAN_RATE);
  localparam int PW = $clog2(NUM_ROWS);
  localparam int CW = $clog2((BASE_ON << 2) + 1);
  typedef enum logic [2:0] {REQ, WAIT, SHIFT, LATCH, DISPLAY} state_t;
  state_t                                  state;
  logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0]   cap;
  logic [AW-1:0]                           cap_addr;
  logic [1:0]                              plane;
  logic [PW-1:0]                           pix;
  logic                                    phase;
  logic [CW-1:0]                           cnt;
  logic                                    unused_col_num2;
  assign unused_col_num2 = ^col_num2;
  function automatic logic [2:0] plane_bits(input logic [RGB_RES-1:0] p, input logic [1:0] b);
    logic [2:0] r, g, bl;
    r  = p[8:6];
    g  = p[5:3];
    bl = p[2:0];
    return {r[b], g[b], bl[b]};
  endfunction
  // outputs are registered: each edge sets the pins for the cycle that follows
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state       <= REQ;
      hub75_ready <= 1'b0;
      rgb1        <= '0;
      rgb2        <= '0;
      addr        <= '0;
      hub75_clk   <= 1'b0;
      hub75_lat   <= 1'b0;
      hub75_oe_n  <= 1'b1;
      cap         <= '0;
      cap_addr    <= '0;
      plane       <= '0;
      pix         <= '0;
      phase       <= 1'b0;
      cnt         <= '0;
    end else begin
      hub75_ready <= 1'b0;
      hub75_lat   <= 1'b0;
      hub75_oe_n  <= 1'b1;
      hub75_clk   <= 1'b0;
      rgb1        <= '0;
      rgb2        <= '0;
      case (state)
        REQ: begin
          hub75_ready <= 1'b1;
          state       <= WAIT;
        end
        // a strobe seen while the request pulse is still high is dropped
        WAIT: if (data_valid && !hub75_ready) begin
          cap      <= columns;
          cap_addr <= col_num1;
          plane    <= '0;
          pix      <= '0;
          phase    <= 1'b0;
          state    <= SHIFT;
        end
        SHIFT: begin
          rgb1      <= plane_bits(cap[0][pix], plane);
          rgb2      <= plane_bits(cap[1][pix], plane);
          hub75_clk <= phase;
          phase     <= !phase;
          if (phase) begin
            if (pix == PW'(NUM_ROWS - 1)) state <= LATCH;
            else pix <= pix + 1'b1;
          end
        end
        LATCH: begin
          hub75_lat <= 1'b1;
          addr      <= cap_addr;
          cnt       <= CW'(BASE_ON << plane);
          state     <= DISPLAY;
        end
        DISPLAY: begin
          hub75_oe_n <= 1'b0;
          cnt        <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            if (plane == 2'd2) state <= REQ;
            else begin
              plane <= plane + 1'b1;
              pix   <= '0;
              state <= SHIFT;
            end
          end
        end
        default: state <= REQ;
      endcase
    end
  end
endmodule

// File: tb/tb_hub75_column_driver.sv
// tb_hub75_column_driver: directed and random pairs checked against a pixel,
// address and on-time scoreboard plus per-cycle protocol invariants.
module tb_hub75_column_driver;
  typedef logic [1:0][63:0][8:0] cols_t;
  logic       clk_in = 1'b0;
  logic       rst_n_in = 1'b0;
  cols_t      columns = '0;
  logic [4:0] col_num1 = '0;
  logic [5:0] col_num2 = '0;
  logic       data_valid = 1'b0;
  logic       hub75_ready;
  logic [2:0] rgb1, rgb2;
  logic [4:0] addr;
  logic       hub75_clk, hub75_lat, hub75_oe_n;
  int total = 0;
  int bad = 0;
  logic [5:0] q_rgb[$];
  logic [4:0] q_addr[$];
  int         q_on[$];
  logic       pclk = 1'b0;
  logic [4:0] paddr = '0;
  int         on_run = 0;
  int         clk_cnt = 0;

  hub75_column_driver dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .columns(columns), .col_num1(col_num1),
    .col_num2(col_num2), .data_valid(data_valid), .hub75_ready(hub75_ready),
    .rgb1(rgb1), .rgb2(rgb2), .addr(addr), .hub75_clk(hub75_clk),
    .hub75_lat(hub75_lat), .hub75_oe_n(hub75_oe_n)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] exp_bits(input logic [8:0] p, input int pl);
    logic [8:0] s;
    s = p >> pl;
    return {s[6], s[3], s[0]};
  endfunction

  task automatic push_pair(input cols_t c, input logic [4:0] a);
    for (int pl = 0; pl < 3; pl++) begin
      for (int p = 0; p < 64; p++) q_rgb.push_back({exp_bits(c[0][p], pl), exp_bits(c[1][p], pl)});
      q_addr.push_back(a);
      q_on.push_back(4 << pl);
    end
  endtask

  task automatic send(input cols_t c, input logic [4:0] a, input bit accept);
    columns = c;
    col_num1 = a;
    col_num2 = 6'($urandom);
    data_valid = 1'b1;
    if (accept) push_pair(c, a);
    @(negedge clk_in);
    data_valid = 1'b0;
  endtask

  task automatic wait_ready(input string tag, input int exp_n);
    int n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (!hub75_ready && n < 1000);
    check(tag, n, exp_n);
  endtask

  function automatic cols_t fill(input logic [8:0] up, input logic [8:0] lo);
    cols_t c;
    for (int p = 0; p < 64; p++) begin
      c[0][p] = up;
      c[1][p] = lo;
    end
    return c;
  endfunction

  function automatic cols_t rand_cols();
    cols_t c;
    for (int h = 0; h < 2; h++)
      for (int p = 0; p < 64; p++) c[h][p] = 9'($urandom);
    return c;
  endfunction

  // scoreboard and protocol monitor, sampled mid-cycle
  always @(negedge clk_in) begin
    if (!rst_n_in) begin
      q_rgb.delete();
      q_addr.delete();
      q_on.delete();
      pclk = 1'b0;
      paddr = '0;
      on_run = 0;
      clk_cnt = 0;
    end else begin
      check("lat_oe_excl", 32'(hub75_lat & ~hub75_oe_n), 0);
      check("addr_only_in_latch", 32'(addr != paddr && !hub75_lat), 0);
      if (hub75_lat || !hub75_oe_n) check("rgb_idle", 32'({rgb1, rgb2}), 0);
      if (hub75_clk && !pclk) begin
        clk_cnt++;
        if (q_rgb.size() == 0) check("rgb_unexpected", 32'(q_rgb.size() == 0), 0);
        else check("rgb", 32'({rgb1, rgb2}), 32'(q_rgb.pop_front()));
      end
      if (hub75_lat) begin
        check("clk_edges", clk_cnt, 64);
        clk_cnt = 0;
        if (q_addr.size() == 0) check("addr_unexpected", 32'(q_addr.size() == 0), 0);
        else check("addr", 32'(addr), 32'(q_addr.pop_front()));
      end
      if (!hub75_oe_n) on_run++;
      else if (on_run > 0) begin
        if (q_on.size() == 0) check("oe_unexpected", 32'(q_on.size() == 0), 0);
        else check("oe_len", on_run, q_on.pop_front());
        on_run = 0;
      end
      pclk = hub75_clk;
      paddr = addr;
    end
  end

  initial begin
    cols_t c;
    int cnt;
    int nl;
    repeat (3) @(negedge clk_in);
    check("rst_ready", 32'(hub75_ready), 0);
    check("rst_rgb1", 32'(rgb1), 0);
    check("rst_rgb2", 32'(rgb2), 0);
    check("rst_addr", 32'(addr), 0);
    check("rst_clk", 32'(hub75_clk), 0);
    check("rst_lat", 32'(hub75_lat), 0);
    check("rst_oe_n", 32'(hub75_oe_n), 1);
    rst_n_in = 1'b1;
    @(posedge clk_in); #1;
    check("ready_first", 32'(hub75_ready), 1);
    @(posedge clk_in); #1;
    check("ready_one_cycle", 32'(hub75_ready), 0);
    cnt = 0;
    repeat (1000) begin
      @(negedge clk_in);
      if (hub75_ready) cnt++;
    end
    check("ready_idle", cnt, 0);
    send(fill(9'h1C0, 9'h007), 5'd5, 1'b1);
    repeat (10) @(negedge clk_in);
    send(fill(9'h1FF, 9'h1FF), 5'd9, 1'b0);
    wait_ready("period_solid", 405);
    check("addr_hold", 32'(addr), 5);
    @(negedge clk_in);
    c = rand_cols();
    c[0][0] = 9'b011_000_101;
    send(c, 5'd12, 1'b1);
    wait_ready("period_bcm", 416);
    send(fill(9'h0AA, 9'h155), 5'd7, 1'b0);
    send(rand_cols(), 5'd8, 1'b1);
    wait_ready("period_after_drop", 416);
    @(negedge clk_in);
    send(rand_cols(), 5'd3, 1'b1);
    nl = 0;
    cnt = 0;
    while (nl < 2 && cnt < 2000) begin
      @(negedge clk_in);
      cnt++;
      if (hub75_lat) nl++;
    end
    check("plane1_latch_seen", nl, 2);
    repeat (3) @(negedge clk_in);
    check("plane1_on", 32'(hub75_oe_n), 0);
    #1 rst_n_in = 1'b0;
    #1;
    check("async_oe_n", 32'(hub75_oe_n), 1);
    check("async_addr", 32'(addr), 0);
    check("async_rgb1", 32'(rgb1), 0);
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    @(posedge clk_in); #1;
    check("ready_restart", 32'(hub75_ready), 1);
    repeat (2) @(negedge clk_in);
    for (int i = 0; i < 50; i++) begin
      send(rand_cols(), 5'($urandom), 1'b1);
      wait_ready("period_rand", 416);
      @(negedge clk_in);
    end
    @(negedge clk_in);
    check("rgb_drained", q_rgb.size(), 0);
    check("addr_drained", q_addr.size(), 0);
    check("oe_drained", q_on.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hub75_column_driver.md
Name: hub75_column_driver

Overview:
- Consumer end of the column-streaming handshake: requests one column pair per cycle with a single-cycle `hub75_ready` pulse.
- Captures the pair on `data_valid` and drives it onto a HUB75 panel as 3-plane binary-coded modulation (BCM).
- Plane sequence: shift 64 pixels, latch the row address, enable output for a weighted time.
- Sits between the frame manager and the panel connector pins.

Parameters:
- NUM_ROWS, 64, pixels per column (shifted per half-panel).
- SCAN_RATE, 32, number of panel addresses; address width is clog2(SCAN_RATE).
- RGB_RES, 9, bits per pixel: {R[2:0],G[2:0],B[2:0]}, R in [8:6], G in [5:3], B in [2:0].
- BASE_ON, 4, OE-active cycles for bit-plane 0; plane b is on for BASE_ON<<b cycles.

Ports:
- clk_in, input, 1, system clock.
- rst_n_in, input, 1, asynchronous active-low reset.
- columns, input, [1:0][NUM_ROWS-1:0][RGB_RES-1:0], column pair; [0] is the upper half, [1] is the lower half.
- col_num1, input, clog2(SCAN_RATE), panel address for the pair.
- col_num2, input, clog2(SCAN_RATE)+1, lower-half column index; accepted, unused (debug only).
- data_valid, input, 1, one-cycle strobe qualifying columns/col_num1.
- hub75_ready, output, 1, one-cycle request for the next pair.
- rgb1, output, 3, {R,G,B} serial data for the upper half.
- rgb2, output, 3, {R,G,B} serial data for the lower half.
- addr, output, clog2(SCAN_RATE), panel row address A..E.
- hub75_clk, output, 1, panel shift clock.
- hub75_lat, output, 1, panel latch.
- hub75_oe_n, output, 1, panel output enable, active low.

Behaviour:
- Reset (async, rst_n_in=0): hub75_ready=0, rgb1=rgb2=0, addr=0, hub75_clk=0, hub75_lat=0, hub75_oe_n=1.
  - Capture registers cleared.
  - FSM to REQ, plane=0.
  - Reset mid-shift or mid-display blanks immediately (oe_n=1 asynchronously).
- FSM states: REQ, WAIT, SHIFT, LATCH, DISPLAY.
- REQ:
  - hub75_ready=1 for exactly one cycle, then WAIT.
  - First REQ cycle is the first clock edge after reset release.
- WAIT:
  - hub75_ready=0. On data_valid=1: capture columns and col_num1, plane=0, pix=0, phase=0, go SHIFT.
  - Waits indefinitely. data_valid in any other state is ignored; the capture regs are not disturbed.
  - data_valid in the same cycle as hub75_ready is accepted only in WAIT, so a strobe coincident with the REQ cycle is dropped.
- SHIFT: two cycles per pixel.
  - phase 0: hub75_clk=0; rgb1/rgb2 = bit `plane` of R,G,B of columns[0][pix] / columns[1][pix].
  - phase 1: hub75_clk=1, data held.
  - pix runs 0..NUM_ROWS-1; pixel 0 is shifted first.
  - After phase 1 of pix=NUM_ROWS-1, go LATCH.
  - Shift length: exactly 2*NUM_ROWS cycles (128 at default).
  - hub75_oe_n=1 throughout; no overlap with display.
- LATCH: one cycle.
  - hub75_lat=1, hub75_clk=0, oe_n=1.
  - addr updates to the captured col_num1 in this cycle and holds until the next LATCH.
- DISPLAY:
  - hub75_oe_n=0 for BASE_ON<<plane cycles, down-counter sized for BASE_ON<<2.
  - Then oe_n=1 and:
    - if plane<2: plane++, pix=0, go SHIFT.
    - if plane==2: go REQ.
- Per-pair period at default, from data_valid acceptance to the next hub75_ready:
  - 3*(128+1) + 4+8+16 = 415 cycles, plus 1 cycle for WAIT→SHIFT.
- hub75_lat and hub75_oe_n are never both active.
- rgb outputs return to 0 outside SHIFT.
- addr wraps naturally within clog2(SCAN_RATE) bits; no range check.

Test Plan:
- Reset then release:
  - All outputs at reset values while rst_n_in=0.
  - hub75_ready pulses high for exactly 1 cycle on the first edge after release, then stays 0 with no data_valid for 1000 cycles.
- Accept pair: columns[0] all 9'h1C0 (R=7), columns[1] all 9'h007 (B=7), col_num1=5.
  - rgb1=3'b100 and rgb2=3'b001 on every phase-0/1 cycle of all 3 planes.
  - 64 hub75_clk rising edges per plane.
  - addr=5 from the first LATCH.
- BCM weighting: pixel 9'b011_000_101 (R=3, B=5) at pix 0.
  - plane0 rgb1=3'b101, plane1 3'b100, plane2 3'b001.
  - OE-low durations 4, 8, 16 cycles.
  - Next hub75_ready 416 cycles after the data_valid edge.
- Handshake rules:
  - data_valid during SHIFT changes no captured data.
  - data_valid coincident with the REQ cycle is dropped; a subsequent strobe in WAIT is accepted.
- Async reset asserted mid-DISPLAY of plane 1:
  - oe_n=1 and addr=0 before the next clock edge.
  - After release, the FSM restarts at REQ.
- Protocol invariant check over 50 random pairs:
  - lat and !oe_n never both 1.
  - addr changes only in LATCH cycles.
